w_id_queue: RTL and testbench
=============================

W_ID_QUEUE -- requirements
Module: w_id_queue

Interface
REQ-001 Parameter id_pad, default 4: sequence-tag width prepended to the master ID.
REQ-002 Parameter id_width, default 2: master ID width.
REQ-003 Parameter depth, default 4: outstanding write-address entries; power of two, at least 2.
REQ-004 Aclk  input  1  single clock; all state updates on the rising edge.
REQ-005 ARESETnRst  input  1  reset, asynchronous, active-low.
REQ-006 AWID  input  id_width+id_pad  extended write ID {seq, master ID} from the ID generator.
REQ-007 AW_valid  input  1  write-address valid from master side.
REQ-008 AW_Ready  input  1  write-address ready from slave side.
REQ-009 AW_valid_o  output  1  AW_valid gated by not-full, to slave.
REQ-010 AW_Ready_o  output  1  AW_Ready gated by not-full, to master.
REQ-011 W_valid  input  1  write-data valid from master.
REQ-012 W_last  input  1  last beat of burst.
REQ-013 W_Ready  input  1  write-data ready from slave.
REQ-014 W_valid_o  output  1  W_valid gated by not-empty, to slave.
REQ-015 W_Ready_o  output  1  W_Ready gated by not-empty, to master.
REQ-016 WID  output  id_width+id_pad  extended ID of the burst at queue head; zero when empty.
REQ-017 W_beat_cnt  output  8  beats accepted in the current burst.
REQ-018 occupancy  output  clog2(depth)+1  entries held.
REQ-019 full, empty  output  1 each  queue status flags.
REQ-020 burst_err  output  1  sticky: beat counter reached 255 without W_last.

Function
REQ-021 Push: on a cycle with AW_valid && AW_Ready && !full, AWID is written at the tail and the tail pointer advances modulo depth.
REQ-022 AW_valid_o = AW_valid && !full; AW_Ready_o = AW_Ready && !full; both combinational.
REQ-023 W_valid_o = W_valid && !empty; W_Ready_o = W_Ready && !empty; both combinational.
REQ-024 A W beat is accepted on a cycle with W_valid && W_Ready && !empty.
REQ-025 An accepted beat with W_last=0 increments W_beat_cnt, saturating at 255; reaching 255 sets burst_err.
REQ-026 An accepted beat with W_last=1 pops the head, advances the head pointer modulo depth, and clears W_beat_cnt to 0.
REQ-027 WID is a combinational read of the head entry; it is registered-stable for the whole burst.
REQ-028 Latency: an entry pushed in cycle N is visible on WID, and empty deasserts, in cycle N+1; there is no same-cycle bypass when empty.
REQ-029 Simultaneous push and pop when neither full nor empty: occupancy is unchanged and both pointers advance.
REQ-030 Push and pop in the same cycle while full: the pop proceeds and the push is blocked; full evaluates from registered state only.
REQ-031 full = (occupancy == depth); empty = (occupancy == 0).
REQ-032 Pointers are clog2(depth) bits and wrap silently; occupancy never exceeds depth nor underflows.
REQ-033 burst_err clears only on reset.

Reset
REQ-034 Assertion of ARESETnRst, asynchronous and at any time including mid-burst, sets head=tail=0, occupancy=0, empty=1, full=0, W_beat_cnt=0, burst_err=0.
REQ-035 While in reset, WID=0, W_valid_o=0, and W_Ready_o=0.
REQ-036 Storage array contents are don't-care after reset.
REQ-037 Deassertion is synchronised externally; the block adds no synchroniser.

Structure
REQ-038 The id_pad, id_width, and extended-ID width localparam, plus the extended-ID typedef, reside in the shared axi_node package, shared with the ID generator.
REQ-039 Storage and pointers are one sub-module, id_fifo (parameterised width and depth, push/pop/full/empty/count).
REQ-040 The top holds only handshake gating, the beat counter, and burst_err.

Verification
REQ-041 Single burst: push AWID=0x13; four W beats with W_last on the 4th -> WID=0x13 for all beats, W_beat_cnt 0,1,2,3, then 0; empty=1 afterwards.
REQ-042 Fill: push 4 IDs with no W traffic -> full=1, occupancy=4; 5th AW_valid -> AW_Ready_o=0 and AW_valid_o=0.
REQ-043 Ordering and wrap: push 0x01,0x12,0x23,0x30, pop two, push 0x05,0x16 -> WID order 0x23,0x30,0x05,0x16.
REQ-044 Simultaneous push/pop at occupancy=2 -> occupancy stays 2; at full, pop accepted and push blocked -> occupancy=3.
REQ-045 Empty gating: W_valid=1 with empty=1 -> W_valid_o=0 and W_Ready_o=0; after push, beat accepted the next cycle.
REQ-046 Reset mid-burst at W_beat_cnt=5, occupancy=3 -> all outputs reach reset values immediately, without a clock edge; 256 beats without W_last -> burst_err=1, W_beat_cnt=255.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: extended write-ID layout used by the ID generator
// and the write-ID queue.
package axi_node;

   localparam int ID_PAD   = 4;
   localparam int ID_WIDTH = 2;
   localparam int EXT_ID_W = ID_WIDTH + ID_PAD;

   typedef logic [EXT_ID_W-1:0] ext_id_t;

   localparam logic [7:0] BEAT_MAX = 8'hFF;

endpackage

// File: rtl/id_fifo.sv
// Circular FIFO of extended IDs with registered pointers and occupancy count.
// Full/empty come from registered state only; a blocked push or pop is ignored.
module id_fifo #(
   parameter  int WIDTH = 6,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign count_o = count_q;

   // Head entry is presented combinationally; an empty queue shows zero.
   assign rdata_o = empty_o ? '0 : mem_q[head_q];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_ok) tail_d = tail_q + PTR_W'(1);
      if (pop_ok)  head_d = head_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only read once count covers them.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[tail_q] <= wdata_i;
   end

endmodule

// File: rtl/w_id_queue.sv
// Write-ID queue: holds AW IDs in issue order and tags W bursts with the head ID,
// gating both handshakes on queue state and tracking beats per burst.
module w_id_queue
   import axi_node::*;
#(
   parameter int id_pad   = ID_PAD,
   parameter int id_width = ID_WIDTH,
   parameter int depth    = 4
) (
   input  logic                         Aclk,
   input  logic                         ARESETnRst,
   input  logic [id_width+id_pad-1:0]   AWID,
   input  logic                         AW_valid,
   input  logic                         AW_Ready,
   output logic                         AW_valid_o,
   output logic                         AW_Ready_o,
   input  logic                         W_valid,
   input  logic                         W_last,
   input  logic                         W_Ready,
   output logic                         W_valid_o,
   output logic                         W_Ready_o,
   output logic [id_width+id_pad-1:0]   WID,
   output logic [7:0]                   W_beat_cnt,
   output logic [$clog2(depth):0]       occupancy,
   output logic                         full,
   output logic                         empty,
   output logic                         burst_err
);

   localparam int XW = id_width + id_pad;

   logic       push, beat_acc, pop;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic       burst_err_q, burst_err_d;

   assign push     = AW_valid && AW_Ready && !full;
   assign beat_acc = W_valid && W_Ready && !empty;
   assign pop      = beat_acc && W_last;

   assign AW_valid_o = AW_valid && !full;
   assign AW_Ready_o = AW_Ready && !full;
   assign W_valid_o  = W_valid && !empty;
   assign W_Ready_o  = W_Ready && !empty;

   id_fifo #(
      .WIDTH (XW),
      .DEPTH (depth)
   ) u_fifo (
      .clk_i   (Aclk),
      .rst_ni  (ARESETnRst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (AWID),
      .rdata_o (WID),
      .full_o  (full),
      .empty_o (empty),
      .count_o (occupancy)
   );

   // Counter saturates; the beat that lands it on BEAT_MAX flags the runaway burst.
   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      burst_err_d = burst_err_q;
      if (beat_acc) begin
         if (W_last) begin
            beat_cnt_d = '0;
         end else if (beat_cnt_q != BEAT_MAX) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (beat_cnt_q == BEAT_MAX - 8'd1) burst_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Aclk or negedge ARESETnRst) begin
      if (!ARESETnRst) begin
         beat_cnt_q  <= '0;
         burst_err_q <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         burst_err_q <= burst_err_d;
      end
   end

   assign W_beat_cnt = beat_cnt_q;
   assign burst_err  = burst_err_q;

endmodule

// File: tb/tb_w_id_queue.sv
// Self-checking bench for w_id_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_w_id_queue;
   import axi_node::*;

   localparam int DEPTH = 4;
   localparam int W     = EXT_ID_W;

   logic         Aclk = 1'b0;
   logic         ARESETnRst;
   logic [W-1:0] AWID;
   logic         AW_valid, AW_Ready, W_valid, W_last, W_Ready;
   logic         AW_valid_o, AW_Ready_o, W_valid_o, W_Ready_o;
   logic [W-1:0] WID;
   logic [7:0]   W_beat_cnt;
   logic [2:0]   occupancy;
   logic         full, empty, burst_err;

   w_id_queue #(.id_pad(ID_PAD), .id_width(ID_WIDTH), .depth(DEPTH)) dut (
      .Aclk       (Aclk),
      .ARESETnRst (ARESETnRst),
      .AWID       (AWID),
      .AW_valid   (AW_valid),
      .AW_Ready   (AW_Ready),
      .AW_valid_o (AW_valid_o),
      .AW_Ready_o (AW_Ready_o),
      .W_valid    (W_valid),
      .W_last     (W_last),
      .W_Ready    (W_Ready),
      .W_valid_o  (W_valid_o),
      .W_Ready_o  (W_Ready_o),
      .WID        (WID),
      .W_beat_cnt (W_beat_cnt),
      .occupancy  (occupancy),
      .full       (full),
      .empty      (empty),
      .burst_err  (burst_err)
   );

   always #5 Aclk = ~Aclk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: ordered list of outstanding IDs plus burst beat count.
   logic [W-1:0] mq[$];
   int           m_cnt;
   bit           m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   task automatic compare_model();
      bit           e_full, e_empty;
      logic [W-1:0] e_wid;
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      e_wid   = '0;
      if (!e_empty) e_wid = mq[0];
      check("occupancy",  occupancy,  mq.size());
      check("full",       full,       e_full);
      check("empty",      empty,      e_empty);
      check("WID",        WID,        e_wid);
      check("W_beat_cnt", W_beat_cnt, m_cnt);
      check("burst_err",  burst_err,  m_err);
      check("AW_valid_o", AW_valid_o, AW_valid && !e_full);
      check("AW_Ready_o", AW_Ready_o, AW_Ready && !e_full);
      check("W_valid_o",  W_valid_o,  W_valid && !e_empty);
      check("W_Ready_o",  W_Ready_o,  W_Ready && !e_empty);
   endtask

   task automatic model_update();
      bit do_push, do_beat;
      do_push = AW_valid && AW_Ready && (mq.size() < DEPTH);
      do_beat = W_valid && W_Ready && (mq.size() > 0);
      if (do_beat) begin
         if (W_last) begin
            void'(mq.pop_front());
            m_cnt = 0;
         end else if (m_cnt < 255) begin
            m_cnt++;
            if (m_cnt == 255) m_err = 1'b1;
         end
      end
      if (do_push) mq.push_back(AWID);
   endtask

   task automatic drive(input logic awv, input logic awr, input logic [W-1:0] id,
                        input logic wv, input logic wl, input logic wr);
      @(negedge Aclk);
      AW_valid = awv; AW_Ready = awr; AWID = id;
      W_valid  = wv;  W_last   = wl;  W_Ready = wr;
      #1 compare_model();
   endtask

   task automatic tick();
      @(posedge Aclk);
      model_update();
   endtask

   task automatic push_id(input logic [W-1:0] id);
      drive(1'b1, 1'b1, id, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic beat(input logic last);
      drive(1'b0, 1'b0, '0, 1'b1, last, 1'b1);
      tick();
   endtask

   task automatic pop_expect(input logic [W-1:0] id);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      check("pop_order_WID", WID, id);
      tick();
   endtask

   task automatic do_reset();
      @(negedge Aclk);
      #2 ARESETnRst = 1'b0;
      model_reset();
      @(negedge Aclk);
      AW_valid = 0; AW_Ready = 0; W_valid = 0; W_last = 0; W_Ready = 0; AWID = '0;
      ARESETnRst = 1'b1;
   endtask

   initial begin
      logic [W-1:0] order [4];
      ARESETnRst = 1'b0;
      AW_valid = 0; AW_Ready = 0; W_valid = 0; W_last = 0; W_Ready = 0; AWID = '0;
      model_reset();
      #1;
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_occupancy", occupancy, 0);
      check("rst_WID", WID, 0);
      repeat (2) @(posedge Aclk);
      @(negedge Aclk);
      ARESETnRst = 1'b1;

      // Single burst of four beats on ID 0x13.
      push_id(6'h13);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, '0, 1'b1, (i == 3), 1'b1);
         check("burst_WID", WID, 6'h13);
         check("burst_cnt", W_beat_cnt, i);
         tick();
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("burst_done_cnt", W_beat_cnt, 0);
      check("burst_done_empty", empty, 1'b1);
      tick();

      // Fill, blocked fifth push, then ordering across the pointer wrap.
      push_id(6'h01); push_id(6'h12); push_id(6'h23); push_id(6'h30);
      drive(1'b1, 1'b1, 6'h3F, 1'b0, 1'b0, 1'b0);
      check("fill_full", full, 1'b1);
      check("fill_occupancy", occupancy, 4);
      check("fill_AW_Ready_o", AW_Ready_o, 1'b0);
      check("fill_AW_valid_o", AW_valid_o, 1'b0);
      tick();
      pop_expect(6'h01); pop_expect(6'h12);
      push_id(6'h05); push_id(6'h16);
      order = '{6'h23, 6'h30, 6'h05, 6'h16};
      for (int i = 0; i < 4; i++) pop_expect(order[i]);

      // Simultaneous push/pop at occupancy 2, then at full.
      push_id(6'h0A); push_id(6'h0B);
      drive(1'b1, 1'b1, 6'h0C, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("pushpop_occ2", occupancy, 2);
      tick();
      push_id(6'h0D); push_id(6'h0E);
      drive(1'b1, 1'b1, 6'h0F, 1'b1, 1'b1, 1'b1);
      check("pushpop_full_AW_Ready_o", AW_Ready_o, 1'b0);
      check("pushpop_full_W_Ready_o", W_Ready_o, 1'b1);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("pushpop_full_occ3", occupancy, 3);
      check("pushpop_full_head", WID, 6'h0C);
      tick();
      pop_expect(6'h0C); pop_expect(6'h0D); pop_expect(6'h0E);

      // Empty gating: beat offered while empty, push in the same cycle.
      drive(1'b1, 1'b1, 6'h2A, 1'b1, 1'b1, 1'b1);
      check("empty_W_valid_o", W_valid_o, 1'b0);
      check("empty_W_Ready_o", W_Ready_o, 1'b0);
      check("empty_WID", WID, 0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      check("after_push_W_valid_o", W_valid_o, 1'b1);
      check("after_push_WID", WID, 6'h2A);
      tick();

      // Asynchronous reset mid-burst.
      push_id(6'h31); push_id(6'h32); push_id(6'h33);
      for (int i = 0; i < 5; i++) beat(1'b0);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("midburst_cnt", W_beat_cnt, 5);
      check("midburst_occ", occupancy, 3);
      #1 ARESETnRst = 1'b0;
      #1;
      check("arst_WID", WID, 0);
      check("arst_W_valid_o", W_valid_o, 1'b0);
      check("arst_W_Ready_o", W_Ready_o, 1'b0);
      check("arst_occupancy", occupancy, 0);
      check("arst_empty", empty, 1'b1);
      check("arst_cnt", W_beat_cnt, 0);
      model_reset();
      @(negedge Aclk);
      W_valid = 0; W_Ready = 0;
      ARESETnRst = 1'b1;

      // Runaway burst: 256 beats without W_last.
      push_id(6'h3C);
      for (int i = 0; i < 256; i++) beat(1'b0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("runaway_err", burst_err, 1'b1);
      check("runaway_cnt", W_beat_cnt, 255);
      tick();
      beat(1'b1);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("err_sticky", burst_err, 1'b1);
      tick();
      do_reset();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 63)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) != 0));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
